// File: rtl/lfsr_prbs_gen.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_prbs_gen
//  Purpose  : Parametrised Fibonacci/Galois LFSR PRBS source with a
//             valid/ready stream, start/stop control and wrap detection.
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr_prbs_gen #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
  parameter bit               GALOIS       = 1'b0,
  parameter int               STEP         = 1,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = '1,
  parameter int               CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  input  logic             load,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] out,
  output logic             prbs_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wrap,
  output logic             seed_err,
  output logic [CNT_W-1:0] adv_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_fsm;
  state_t           w_fsm_nxt;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_start;
  logic             r_wrap;
  logic             r_seed_err;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_adv;
  logic [WIDTH-1:0] w_load_val;
  logic             w_accept;
  logic             w_advance;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    if (GALOIS)
      return (s >> 1) ^ (s[0] ? TAPS : '0);
    else
      return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  // STEP single advances chained combinationally so one beat moves STEP states.
  always_comb begin
    w_adv = r_state;
    for (int k = 0; k < STEP; k++) begin
      w_adv = lfsr_step(w_adv);
    end
  end

  assign w_load_val = (seed != '0) ? seed : SEED_DEFAULT;
  assign w_accept   = out_valid & out_ready;
  assign w_advance  = w_accept & ~load;

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (start && !stop) w_fsm_nxt = S_RUN;
      S_RUN:   if (stop)           w_fsm_nxt = S_IDLE;
      default:                     w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Load overrides a coincident accepted beat; the counter still clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= SEED_DEFAULT;
      r_start    <= SEED_DEFAULT;
      r_wrap     <= 1'b0;
      r_seed_err <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_wrap     <= 1'b0;
      r_seed_err <= 1'b0;
      if (load) begin
        r_state    <= w_load_val;
        r_start    <= w_load_val;
        r_seed_err <= (seed == '0);
        r_cnt      <= '0;
      end else if (w_advance) begin
        r_state <= w_adv;
        r_wrap  <= (w_adv == r_start);
        if (r_cnt != '1) begin
          r_cnt <= r_cnt + C_CNT_ONE;
        end
      end
    end
  end

  assign out       = r_state;
  assign prbs_bit  = r_state[WIDTH-1];
  assign out_valid = (r_fsm == S_RUN);
  assign wrap      = r_wrap;
  assign seed_err  = r_seed_err;
  assign adv_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_prbs_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_prbs_gen
//  Purpose  : Directed bench for lfsr_prbs_gen: Fibonacci STEP=1, Galois
//             STEP=1 and Fibonacci STEP=2 instances against a bench model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_prbs_gen;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] seed = 4'h0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       out_ready = 1'b0;

  logic [3:0] out_a      [N];
  logic       prbs_a     [N];
  logic       valid_a    [N];
  logic       wrap_a     [N];
  logic       err_a      [N];
  logic [4:0] cnt_a      [N];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr_prbs_gen #(.WIDTH(4), .TAPS(4'hC), .GALOIS(1'b0), .STEP(1), .SEED_DEFAULT(4'hF), .CNT_W(5)) u_fib (
    .clk(clk), .rst(rst), .seed(seed), .load(load), .start(start), .stop(stop),
    .out(out_a[0]), .prbs_bit(prbs_a[0]), .out_valid(valid_a[0]), .out_ready(out_ready),
    .wrap(wrap_a[0]), .seed_err(err_a[0]), .adv_cnt(cnt_a[0]));

  lfsr_prbs_gen #(.WIDTH(4), .TAPS(4'hC), .GALOIS(1'b1), .STEP(1), .SEED_DEFAULT(4'hF), .CNT_W(5)) u_gal (
    .clk(clk), .rst(rst), .seed(seed), .load(load), .start(start), .stop(stop),
    .out(out_a[1]), .prbs_bit(prbs_a[1]), .out_valid(valid_a[1]), .out_ready(out_ready),
    .wrap(wrap_a[1]), .seed_err(err_a[1]), .adv_cnt(cnt_a[1]));

  lfsr_prbs_gen #(.WIDTH(4), .TAPS(4'hC), .GALOIS(1'b0), .STEP(2), .SEED_DEFAULT(4'hF), .CNT_W(5)) u_fib2 (
    .clk(clk), .rst(rst), .seed(seed), .load(load), .start(start), .stop(stop),
    .out(out_a[2]), .prbs_bit(prbs_a[2]), .out_valid(valid_a[2]), .out_ready(out_ready),
    .wrap(wrap_a[2]), .seed_err(err_a[2]), .adv_cnt(cnt_a[2]));

  // Model: states as integers, advance computed from the polynomial definition.
  bit         m_gal [N] = '{1'b0, 1'b1, 1'b0};
  int         m_stp [N] = '{1, 1, 2};
  logic [3:0] m_out   [N];
  logic [3:0] m_start [N];
  bit         m_run   [N];
  bit         m_wrap  [N];
  bit         m_err   [N];
  int         m_cnt   [N];

  function automatic logic [3:0] m_adv(input logic [3:0] s, input bit gal);
    int v;
    v = int'(s);
    if (gal)
      return (v % 2 == 1) ? 4'((v / 2) ^ 12) : 4'(v / 2);
    else
      return 4'(((v * 2) % 16) + ($countones(s & 4'hC) % 2));
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_out[i] = 4'hF; m_start[i] = 4'hF; m_run[i] = 1'b0;
        m_wrap[i] = 1'b0; m_err[i] = 1'b0; m_cnt[i] = 0;
      end else begin
        bit acc;
        acc = m_run[i] && out_ready;
        m_wrap[i] = 1'b0;
        m_err[i]  = 1'b0;
        if (load) begin
          m_out[i]   = (seed == 4'h0) ? 4'hF : seed;
          m_start[i] = m_out[i];
          m_err[i]   = (seed == 4'h0);
          m_cnt[i]   = 0;
        end else if (acc) begin
          for (int k = 0; k < m_stp[i]; k++) m_out[i] = m_adv(m_out[i], m_gal[i]);
          m_wrap[i] = (m_out[i] == m_start[i]);
          if (m_cnt[i] < 31) m_cnt[i] = m_cnt[i] + 1;
        end
        if (stop) m_run[i] = 1'b0;
        else if (start) m_run[i] = 1'b1;
      end
    end
  end

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h required=%0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      check("out",       i, 32'(out_a[i]),   32'(m_out[i]));
      check("prbs_bit",  i, 32'(prbs_a[i]),  32'(m_out[i][3]));
      check("out_valid", i, 32'(valid_a[i]), 32'(m_run[i]));
      check("wrap",      i, 32'(wrap_a[i]),  32'(m_wrap[i]));
      check("seed_err",  i, 32'(err_a[i]),   32'(m_err[i]));
      check("adv_cnt",   i, 32'(cnt_a[i]),   32'(m_cnt[i]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    #12;
    check("rst_out", 0, 32'(out_a[0]), 32'hF);
    check("rst_valid", 0, 32'(valid_a[0]), 32'h0);
    rst = 1'b0;

    // Fibonacci / Galois / STEP=2 sequences from seed 1
    tick(); load = 1'b1; seed = 4'h1;
    tick(); load = 1'b0; start = 1'b1;
    tick(); start = 1'b0; out_ready = 1'b1;
    for (int b = 1; b <= 35; b++) begin
      tick();
      case (b)
        1: begin
          check("fib_b1", 0, 32'(out_a[0]), 32'h2);
          check("gal_b1", 1, 32'(out_a[1]), 32'hC);
          check("step2_b1", 2, 32'(out_a[2]), 32'h4);
        end
        2: begin check("fib_b2", 0, 32'(out_a[0]), 32'h4); check("gal_b2", 1, 32'(out_a[1]), 32'h6); end
        3: begin check("fib_b3", 0, 32'(out_a[0]), 32'h9); check("gal_b3", 1, 32'(out_a[1]), 32'h3); end
        4: begin check("fib_b4", 0, 32'(out_a[0]), 32'h3); check("gal_b4", 1, 32'(out_a[1]), 32'hD); end
        14: check("nowrap_b14", 0, 32'(wrap_a[0]), 32'h0);
        15: begin
          check("wrap_out_b15", 0, 32'(out_a[0]), 32'h1);
          check("wrap_b15", 0, 32'(wrap_a[0]), 32'h1);
          check("cnt_b15", 0, 32'(cnt_a[0]), 32'd15);
        end
        30: begin check("wrap_b30", 0, 32'(wrap_a[0]), 32'h1); check("cnt_b30", 0, 32'(cnt_a[0]), 32'd30); end
        35: check("cnt_sat", 0, 32'(cnt_a[0]), 32'd31);
        default: ;
      endcase
    end

    // Backpressure: ready 1,0,0,1 gives two advances
    out_ready = 1'b0; load = 1'b1; seed = 4'h1;
    tick(); load = 1'b0;
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    check("bp_hold1", 0, 32'(out_a[0]), 32'h2);
    check("bp_valid", 0, 32'(valid_a[0]), 32'h1);
    tick();
    check("bp_hold2", 0, 32'(out_a[0]), 32'h2);
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    check("bp_out", 0, 32'(out_a[0]), 32'h4);
    check("bp_cnt", 0, 32'(cnt_a[0]), 32'd2);

    // Zero seed substitution
    load = 1'b1; seed = 4'h0;
    tick(); load = 1'b0;
    check("zs_out", 0, 32'(out_a[0]), 32'hF);
    check("zs_err", 0, 32'(err_a[0]), 32'h1);
    check("zs_cnt", 0, 32'(cnt_a[0]), 32'd0);
    check("zs_wrap", 0, 32'(wrap_a[0]), 32'h0);
    tick();
    check("zs_err_once", 0, 32'(err_a[0]), 32'h0);

    // Load coinciding with an accepted beat
    out_ready = 1'b1; load = 1'b1; seed = 4'h5;
    tick(); load = 1'b0; out_ready = 1'b0;
    check("col_out", 0, 32'(out_a[0]), 32'h5);
    check("col_cnt", 0, 32'(cnt_a[0]), 32'd0);

    // start+stop together in RUN, then no advance in IDLE
    start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0;
    check("ss_valid", 0, 32'(valid_a[0]), 32'h0);
    out_ready = 1'b1; tick();
    check("idle_hold", 0, 32'(out_a[0]), 32'h5);
    out_ready = 1'b0;

    // Asynchronous reset mid-run
    start = 1'b1; tick(); start = 1'b0; out_ready = 1'b1;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      check("arst_out", i, 32'(out_a[i]), 32'hF);
      check("arst_valid", i, 32'(valid_a[i]), 32'h0);
      check("arst_cnt", i, 32'(cnt_a[i]), 32'd0);
    end
    out_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
